// File: rtl/sifh_readout_if.sv
// Readout stream bundle: one histogram bin per beat, valid/ready handshake.
// The master (sifh_readout) drives data and valid; the consumer drives ready.
interface sifh_readout_if #(
  parameter int PEAK_MAX = 8,
  parameter int BIN_BITS = 10,
  parameter int PIX_BITS = 2
);
  logic [PEAK_MAX-1:0] out_data;
  logic [BIN_BITS-1:0] out_bin;
  logic [PIX_BITS-1:0] out_pixel;
  logic                out_last;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output out_data, out_bin, out_pixel, out_last, out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data, out_bin, out_pixel, out_last, out_valid,
    output out_ready
  );
endinterface

// File: rtl/sifh_readout.sv
// Streams every bin of every pixel out of the histogram RAM (port b) and
// reports the per-pixel peak bin/count as each pixel finishes.
module sifh_readout #(
  parameter int PEAK_MAX = 8,
  parameter int BIN_BITS = 10,
  parameter int PIX_BITS = 2
) (
  input  logic                         clk,
  input  logic                         res,
  input  logic                         start,
  output logic [PIX_BITS+BIN_BITS-1:0] raddr,
  output logic                         rEnable,
  output logic                         readFlag,
  input  logic [PEAK_MAX-1:0]          counts,
  sifh_readout_if.master               stream,
  output logic                         peak_valid,
  output logic [BIN_BITS-1:0]          peak_bin,
  output logic [PEAK_MAX-1:0]          peak_count,
  output logic                         busy,
  output logic                         done
);
  localparam int RAM_ADDR = PIX_BITS + BIN_BITS;

  typedef enum logic [2:0] {IDLE, RD, CAP, OUT, PK, FIN} state_t;

  state_t              state;
  logic [PIX_BITS-1:0] pixel;
  logic [BIN_BITS-1:0] bin;

  function automatic logic [RAM_ADDR-1:0] ramAddr(input logic [PIX_BITS-1:0] pix,
                                                  input logic [BIN_BITS-1:0] b);
    return {pix, b};
  endfunction

  // Bin 0 always seeds the peak; afterwards only a strictly larger count
  // replaces it, so the earliest bin wins a tie.
  function automatic logic isNewPeak(input logic [BIN_BITS-1:0] b,
                                     input logic [PEAK_MAX-1:0] c,
                                     input logic [PEAK_MAX-1:0] best);
    return (b == '0) || (c > best);
  endfunction

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state             <= IDLE;
      pixel             <= '0;
      bin               <= '0;
      raddr             <= '0;
      rEnable           <= 1'b1;
      readFlag          <= 1'b0;
      stream.out_data   <= '0;
      stream.out_bin    <= '0;
      stream.out_pixel  <= '0;
      stream.out_last   <= 1'b0;
      stream.out_valid  <= 1'b0;
      peak_valid        <= 1'b0;
      peak_bin          <= '0;
      peak_count        <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pixel      <= '0;
            bin        <= '0;
            peak_bin   <= '0;
            peak_count <= '0;
            raddr      <= ramAddr('0, '0);
            rEnable    <= 1'b0;
            readFlag   <= 1'b1;
            busy       <= 1'b1;
            state      <= RD;
          end
        end
        // Read strobe lasts exactly one cycle; data arrives in CAP.
        RD: begin
          rEnable  <= 1'b1;
          readFlag <= 1'b0;
          state    <= CAP;
        end
        CAP: begin
          stream.out_data  <= counts;
          stream.out_bin   <= bin;
          stream.out_pixel <= pixel;
          stream.out_last  <= (bin == '1) && (pixel == '1);
          stream.out_valid <= 1'b1;
          if (isNewPeak(bin, counts, peak_count)) begin
            peak_bin   <= bin;
            peak_count <= counts;
          end
          state <= OUT;
        end
        // Hold the beat until accepted; the next read is only issued here.
        OUT: begin
          if (stream.out_valid && stream.out_ready) begin
            stream.out_valid <= 1'b0;
            if (bin != '1) begin
              bin      <= bin + 1'b1;
              raddr    <= ramAddr(pixel, bin + 1'b1);
              rEnable  <= 1'b0;
              readFlag <= 1'b1;
              state    <= RD;
            end else begin
              peak_valid <= 1'b1;
              state      <= PK;
            end
          end
        end
        PK: begin
          peak_valid <= 1'b0;
          if (pixel != '1) begin
            pixel      <= pixel + 1'b1;
            bin        <= '0;
            peak_bin   <= '0;
            peak_count <= '0;
            raddr      <= ramAddr(pixel + 1'b1, '0);
            rEnable    <= 1'b0;
            readFlag   <= 1'b1;
            state      <= RD;
          end else begin
            done  <= 1'b1;
            state <= FIN;
          end
        end
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/sifh_readout.md
SIFH_READOUT -- requirements
Module: sifh_readout

Interface
REQ-001 Parameter PEAK_MAX, default 8: histogram count width in bits.
REQ-002 Parameter BIN_BITS, default 10: bin index width; bins per pixel = 2^BIN_BITS.
REQ-003 Parameter PIX_BITS, default 2: pixel index width; pixels per RAM = 2^PIX_BITS.
REQ-004 Derived RAM_ADDR = PIX_BITS+BIN_BITS; RAM address = {pixel, bin}.
REQ-005 One clock, reset asynchronous active-low: clk input 1, rising-edge clock for all state.
REQ-006 res  input  1  asynchronous active-low reset.
REQ-007 start  input  1  one-cycle pulse; begins readout of all pixels.
REQ-008 raddr  output  RAM_ADDR  histogram RAM read address (port b).
REQ-009 rEnable  output  1  RAM port-b read enable, active-low (0 = read).
REQ-010 readFlag  output  1  RAM port-b memory enable, active-high.
REQ-011 counts  input  PEAK_MAX  RAM port-b read data, valid exactly one cycle after a read cycle.
REQ-012 out_data  output  PEAK_MAX  bin count being streamed.
REQ-013 out_bin  output  BIN_BITS  bin index of out_data.
REQ-014 out_pixel  output  PIX_BITS  pixel index of out_data.
REQ-015 out_last  output  1  high with the last bin of the last pixel.
REQ-016 out_valid  output  1  stream valid; out_ready  input  1  consumer ready.
REQ-017 peak_valid  output  1  one-cycle pulse, peak result for out_pixel's just-finished pixel.
REQ-018 peak_bin  output  BIN_BITS; peak_count  output  PEAK_MAX  per-pixel peak result.
REQ-019 busy  output  1  high from accepted start until done; done  output  1  one-cycle pulse at completion.

Function
REQ-020 FSM states IDLE, RD, CAP, OUT, PK, FIN; reset state IDLE.
REQ-021 IDLE: start=1 -> RD with pixel=0, bin=0, peak registers cleared; start ignored in all other states.
REQ-022 RD (one cycle): rEnable=0, readFlag=1, raddr={pixel,bin}; -> CAP. Outside RD: rEnable=1, readFlag=0.
REQ-023 CAP (one cycle): register counts into out_data, set out_bin/out_pixel/out_last; update peak if counts > peak_count (strict, earliest bin wins ties; bin 0 always loads); -> OUT.
REQ-024 OUT: out_valid=1, out_data/out_bin/out_pixel/out_last held stable until out_valid&&out_ready; no new RAM read issued while stalled.
REQ-025 On handshake in OUT: bin<max -> bin+1, RD; bin==max -> PK.
REQ-026 PK (one cycle): peak_valid=1 with peak_bin/peak_count of current pixel; then pixel<max -> pixel+1, bin=0, peak cleared, RD; pixel==max -> FIN.
REQ-027 FIN (one cycle): done=1, busy=0 next cycle; -> IDLE.
REQ-028 busy=1 in RD, CAP, OUT, PK, FIN; 0 in IDLE.
REQ-029 Minimum 3 cycles per bin (RD, CAP, OUT with ready=1) plus 1 PK cycle per pixel; first RAM read cycle is the cycle after start.
REQ-030 Bin and pixel counters wrap to 0 only via REQ-026; no address beyond 2^RAM_ADDR-1 issued.
REQ-031 Count of all-ones (saturated) is compared and streamed as an ordinary value.
REQ-032 out_last=1 only for bin==max and pixel==max; 0 otherwise.

Reset
REQ-033 res=0 at any time, including mid-readout, forces IDLE immediately: raddr=0, rEnable=1, readFlag=0, out_*=0, out_valid=0, peak_*=0, busy=0, done=0.
REQ-034 After res deasserts, no activity until a new start pulse; interrupted readout is not resumed.

Verification (bench: BIN_BITS=2, PIX_BITS=1, PEAK_MAX=8)
REQ-035 RAM pixel0={3,9,9,1}, pixel1={0,0,0,0}, start, out_ready=1 -> 8 beats in address order, peak_valid for pixel0 with bin=1,count=9; pixel1 with bin=0,count=0; out_last on beat 8; done 27 cycles after start.
REQ-036 out_ready=0 for 5 cycles during beat 2 -> out_data/out_bin stable, rEnable stays 1 throughout stall, no beat lost or duplicated.
REQ-037 Pixel1={255,255,254,255} -> peak bin=0, count=255.
REQ-038 start pulsed again while busy -> ignored; sequence and done timing identical to REQ-035.
REQ-039 res=0 during pixel1 bin2 OUT -> all outputs at reset values same cycle; new start restarts at address 0.
REQ-040 Every RAM read checked: counts sampled exactly one cycle after rEnable=0 matches model for that raddr.
